// File: rtl/svc_pix_fb_if.sv
// Pixel stream and AXI write-channel bundles used by the frame buffer writer.
// master drives the forward payload; slave returns the ready/response side.
interface svc_pix_if #(
    parameter int COLOR_WIDTH = 4
);
    logic                   valid;
    logic                   ready;
    logic [COLOR_WIDTH-1:0] red;
    logic [COLOR_WIDTH-1:0] grn;
    logic [COLOR_WIDTH-1:0] blu;

    modport master (output valid, red, grn, blu, input ready);
    modport slave  (input valid, red, grn, blu, output ready);
endinterface

interface svc_axi_wr_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );
    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/svc_pix_fb.sv
// Raster pixel stream -> one single-beat AXI write per pixel, address wraps to 0 at frame end.
// AW/W issued 1 clk after accept; ready drops while AW or W stalls or MAX_OUTSTANDING writes lack a B.
// Optional SVC_PIX_FB_ERR_EN adds a sticky err output for non-OKAY write responses.
module svc_pix_fb #(
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int COLOR_WIDTH     = 4,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    svc_pix_if.slave           s_pix,
    svc_axi_wr_if.master       m_axi,
    input  logic [H_WIDTH-1:0] h_visible,
    input  logic [V_WIDTH-1:0] v_visible,
`ifdef SVC_PIX_FB_ERR_EN
    output logic               err,
`endif
    output logic               idle
);

    localparam int PIXEL_WIDTH = 3 * COLOR_WIDTH;
    localparam int AXSIZE      = $clog2(AXI_DATA_WIDTH / 8);
    localparam int PEND_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PEND_WIDTH-1:0]     PEND_MAX  = PEND_WIDTH'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(1 << AXSIZE);

    logic                      awvalid_q;
    logic                      wvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [H_WIDTH-1:0]        x_q;
    logic [V_WIDTH-1:0]        y_q;
    logic [PEND_WIDTH-1:0]     pend_q;
    logic [PIXEL_WIDTH-1:0]    pix_dat;
    logic                      pix_fire;
    logic                      b_fire;
    logic                      b_take;
    logic                      x_last;
    logic                      y_last;

    assign pix_dat  = {s_pix.red, s_pix.grn, s_pix.blu};
    assign pix_fire = s_pix.valid && s_pix.ready;
    assign b_fire   = m_axi.bvalid && m_axi.bready;
    // A response with nothing outstanding (stray after reset) must not underflow the count.
    assign b_take   = b_fire && (pend_q != '0);
    assign x_last   = (x_q == h_visible - H_WIDTH'(1));
    assign y_last   = (y_q == v_visible - V_WIDTH'(1));

    assign s_pix.ready = (!awvalid_q || m_axi.awready) &&
                         (!wvalid_q  || m_axi.wready)  &&
                         (pend_q < PEND_MAX);

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awid    = AXI_ID_WIDTH'(0);
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'(AXSIZE);
    assign m_axi.awburst = 2'b01;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = !rst;

    assign idle = !awvalid_q && !wvalid_q && (pend_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else if (pix_fire) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= addr_q;
            wdata_q   <= AXI_DATA_WIDTH'(pix_dat);
        end else begin
            if (m_axi.awready) awvalid_q <= 1'b0;
            if (m_axi.wready)  wvalid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (pix_fire) begin
            if (!x_last) begin
                x_q    <= x_q + H_WIDTH'(1);
                addr_q <= addr_q + ADDR_STEP;
            end else if (!y_last) begin
                x_q    <= '0;
                y_q    <= y_q + V_WIDTH'(1);
                addr_q <= addr_q + ADDR_STEP;
            end else begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else if (pix_fire && !b_take) begin
            pend_q <= pend_q + PEND_WIDTH'(1);
        end else if (!pix_fire && b_take) begin
            pend_q <= pend_q - PEND_WIDTH'(1);
        end
    end

`ifdef SVC_PIX_FB_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (b_fire && (m_axi.bresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi.bid, m_axi.bresp};

endmodule

// File: tb/tb_svc_pix_fb.sv
// Bench for svc_pix_fb: address/data scoreboard fed at pixel accept, drained at AW/W handshakes,
// plus a B responder that answers one cycle after each W and can be held off.
`timescale 1ns/1ps
module tb_svc_pix_fb;

    localparam int HW = 12, VW = 12, CW = 4, AW = 16, DW = 16, IW = 4, MAXO = 4;
    localparam int H = 4, V = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [HW-1:0] h_visible = HW'(H);
    logic [VW-1:0] v_visible = VW'(V);
    logic          idle;
`ifdef SVC_PIX_FB_ERR_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    svc_pix_if #(.COLOR_WIDTH(CW)) pix ();
    svc_axi_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    svc_pix_fb #(
        .H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW), .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_pix(pix),
        .m_axi(axi),
        .h_visible(h_visible),
        .v_visible(v_visible),
`ifdef SVC_PIX_FB_ERR_EN
        .err(err),
`endif
        .idle(idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and responder state, all owned by the negedge monitor.
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    int mx = 0, my = 0;
    int model_pend = 0;
    int acc_cnt = 0, b_cnt = 0, owed = 0, b_num = 0, coincide = 0;
    bit b_hold = 1'b0;
    int slverr_idx = 0;
    bit exp_err = 1'b0;

    always @(negedge clk) begin : mon
        bit pf, af, wf, bf;
        if (rst) begin
            aw_q.delete();
            w_q.delete();
            mx = 0; my = 0; model_pend = 0; owed = 0; b_num = 0; exp_err = 1'b0;
            axi.bvalid = 1'b0;
            axi.bresp  = 2'b00;
            axi.bid    = '0;
        end else begin
            // Drive B for the coming edge first so fire detection sees what the DUT will see.
            if (!b_hold && owed > 0) begin
                owed--;
                b_num++;
                axi.bvalid = 1'b1;
                axi.bresp  = (b_num == slverr_idx) ? 2'b10 : 2'b00;
            end else begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'b00;
            end
            pf = pix.valid && pix.ready;
            af = axi.awvalid && axi.awready;
            wf = axi.wvalid && axi.wready;
            bf = axi.bvalid && axi.bready;
`ifdef SVC_PIX_FB_ERR_EN
            check_val("err", 32'(err), 32'(exp_err));
            if (bf && axi.bresp != 2'b00) exp_err = 1'b1;
`endif
            if (af) begin
                check_val("aw_expected", 32'(aw_q.size() > 0), 32'd1);
                if (aw_q.size() > 0) check_val("awaddr", 32'(axi.awaddr), 32'(aw_q.pop_front()));
                check_val("aw_fixed", 32'({axi.awid, axi.awlen, axi.awsize, axi.awburst}),
                          32'({4'd0, 8'd0, 3'd1, 2'b01}));
            end
            if (wf) begin
                check_val("w_expected", 32'(w_q.size() > 0), 32'd1);
                if (w_q.size() > 0) check_val("wdata", 32'(axi.wdata), 32'(w_q.pop_front()));
                check_val("w_fixed", 32'({axi.wstrb, axi.wlast}), 32'({2'b11, 1'b1}));
                owed++;
            end
            if (pf) begin
                aw_q.push_back(AW'((my * H + mx) * 2));
                w_q.push_back(DW'({pix.red, pix.grn, pix.blu}));
                mx++;
                if (mx == H) begin
                    mx = 0;
                    my = (my == V - 1) ? 0 : my + 1;
                end
                acc_cnt++;
                model_pend++;
            end
            if (bf) begin
                b_cnt++;
                model_pend--;
            end
            if (pf && bf) coincide++;
        end
    end

    task automatic drive_pix(input logic [11:0] p, input int budget, output bit ok);
        int a0;
        a0 = acc_cnt;
        pix.valid = 1'b1;
        {pix.red, pix.grn, pix.blu} = p;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [11:0] p, input string tag);
        bit ok;
        drive_pix(p, 20, ok);
        check_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (idle) begin
                seen = 1'b1;
                break;
            end
        end
        check_val(tag, 32'(seen), 32'd1);
        check_val("idle_pend", 32'(model_pend), 32'd0);
        check_val("idle_q", 32'(aw_q.size() + w_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        time t0;
        int a0, b0, c0;
        logic [11:0] p;

        pix.valid = 1'b0;
        {pix.red, pix.grn, pix.blu} = 12'h000;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_awvalid", 32'(axi.awvalid), 32'd0);
        check_val("rst_wvalid", 32'(axi.wvalid), 32'd0);
        check_val("rst_awaddr", 32'(axi.awaddr), 32'd0);
        check_val("rst_wdata", 32'(axi.wdata), 32'd0);
        check_val("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        #1;
        check_val("bready", 32'(axi.bready), 32'd1);
        check_val("rdy_after_rst", 32'(pix.ready), 32'd1);

        // Full frame back-to-back plus the wrapped 9th pixel
        @(posedge clk); #1;
        t0 = $time;
        for (int i = 0; i < 9; i++) send(12'($urandom), "b2b_accept");
        check_val("b2b_cycles", 32'((($time - t0) / 10)), 32'd9);
        pix.valid = 1'b0;
        wait_idle("drain_b2b");

        // AW stalled: W retires alone, address held, input stalled
        axi.awready = 1'b0;
        send(12'h5a3, "aw_stall_accept");
        {pix.red, pix.grn, pix.blu} = 12'h3c7;
        check_val("aw_stall_rdy0", 32'(pix.ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("aw_stall_rdy", 32'(pix.ready), 32'd0);
            check_val("aw_stall_wvalid", 32'(axi.wvalid), 32'd0);
            check_val("aw_stall_awvalid", 32'(axi.awvalid), 32'd1);
            check_val("aw_stall_depth", 32'(aw_q.size()), 32'd1);
            if (aw_q.size() > 0) check_val("aw_stall_addr", 32'(axi.awaddr), 32'(aw_q[0]));
        end
        axi.awready = 1'b1;
        send(12'h3c7, "aw_release_accept");
        pix.valid = 1'b0;
        wait_idle("drain_aw_stall");

        // B withheld: exactly MAX_OUTSTANDING accepted
        b_hold = 1'b1;
        a0 = acc_cnt;
        c0 = acc_cnt;
        pix.valid = 1'b1;
        {pix.red, pix.grn, pix.blu} = 12'($urandom);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != c0) begin
                {pix.red, pix.grn, pix.blu} = 12'($urandom);
                c0 = acc_cnt;
            end
        end
        check_val("hold_accepts", 32'(acc_cnt - a0), 32'd4);
        check_val("hold_rdy", 32'(pix.ready), 32'd0);
        check_val("hold_idle", 32'(idle), 32'd0);
        b0 = b_cnt;
        b_hold = 1'b0;
        send(12'($urandom), "release_accept");
        check_val("rdy_after_b", 32'(b_cnt - b0 >= 1), 32'd1);
        pix.valid = 1'b0;
        wait_idle("drain_hold");

        // B and accept on the same edge at pending 3
        b_hold = 1'b1;
        for (int i = 0; i < 3; i++) send(12'($urandom), "pend3_accept");
        pix.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        c0 = coincide;
        b_hold = 1'b0;
        send(12'($urandom), "coincide_accept");
        b_hold = 1'b1;
        pix.valid = 1'b0;
        check_val("coincide_seen", 32'(coincide - c0), 32'd1);
        a0 = acc_cnt;
        pix.valid = 1'b1;
        {pix.red, pix.grn, pix.blu} = 12'h123;
        repeat (6) @(posedge clk);
        #1;
        check_val("pend_after_coincide", 32'(acc_cnt - a0), 32'd1);
        check_val("coincide_rdy", 32'(pix.ready), 32'd0);
        pix.valid = 1'b0;
        b_hold = 1'b0;
        @(posedge clk); #1;
        check_val("idle_while_pend", 32'(idle), 32'd0);
        wait_idle("drain_coincide");

        // Reset mid-line at (2,1)
        do_reset();
        for (int i = 0; i < 6; i++) send(12'($urandom), "pre_rst_accept");
        check_val("pre_rst_awvalid", 32'(axi.awvalid), 32'd1);
        check_val("pre_rst_addr", 32'(axi.awaddr), 32'd10);
        rst = 1'b1;
        #1;
        check_val("mid_rst_awvalid", 32'(axi.awvalid), 32'd0);
        check_val("mid_rst_wvalid", 32'(axi.wvalid), 32'd0);
        check_val("mid_rst_awaddr", 32'(axi.awaddr), 32'd0);
        check_val("mid_rst_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        p = 12'ha5f;
        send(p, "post_rst_accept");
        check_val("post_rst_addr", 32'(axi.awaddr), 32'd0);
        check_val("post_rst_wdata", 32'(axi.wdata), 32'(p));
        pix.valid = 1'b0;
        wait_idle("drain_post_rst");

        // SLVERR on the third response
        slverr_idx = 3;
        do_reset();
        for (int i = 0; i < 5; i++) send(12'($urandom), "err_accept");
        pix.valid = 1'b0;
        wait_idle("drain_err");
`ifdef SVC_PIX_FB_ERR_EN
        check_val("err_sticky", 32'(err), 32'd1);
`endif
        slverr_idx = 0;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
